// File: rtl/core_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states and
// bypass-select bit positions.
package core_pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } pipe_state_e;

    // exe_bp bit positions; a 0 selects the corresponding forward path
    localparam int unsigned M2E_SRC1_MUX = 0;
    localparam int unsigned W2E_SRC1_MUX = 1;
    localparam int unsigned M2E_SRC2_MUX = 2;
    localparam int unsigned W2E_SRC2_MUX = 3;

    // No forwarding on either source
    localparam logic [3:0] BP_NONE = 4'hF;

endpackage

// File: rtl/core_fwd_unit.sv
// Combinational register-index compare: next EXE bypass selects and the
// DEC-vs-EXE hit used for load-use detection.
module core_fwd_unit
    import core_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use1,
    input  logic              i_use2,
    input  logic [REG_AW-1:0] i_exe_rd,
    input  logic              i_exe_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_we,
    input  logic              i_mask,
    output logic [3:0]        o_bp_nxt,
    output logic              o_exe_hit
);

    logic w_m2e1, w_m2e2, w_w2e1, w_w2e2;

    // Index matches against EXE and MEM destinations; x0 never matches
    always_comb begin
        w_m2e1 = i_exe_we && (i_exe_rd != '0) && (i_rs1 == i_exe_rd);
        w_m2e2 = i_exe_we && (i_exe_rd != '0) && (i_rs2 == i_exe_rd);
        w_w2e1 = i_mem_we && (i_mem_rd != '0) && (i_rs1 == i_mem_rd);
        w_w2e2 = i_mem_we && (i_mem_rd != '0) && (i_rs2 == i_mem_rd);
    end

    // Select encoding: the younger (EXE) producer wins over MEM
    always_comb begin
        o_bp_nxt = BP_NONE;
        if (!i_mask) begin
            o_bp_nxt[M2E_SRC1_MUX] = ~w_m2e1;
            o_bp_nxt[W2E_SRC1_MUX] = ~(w_w2e1 & ~w_m2e1);
            o_bp_nxt[M2E_SRC2_MUX] = ~w_m2e2;
            o_bp_nxt[W2E_SRC2_MUX] = ~(w_w2e2 & ~w_m2e2);
        end
        o_exe_hit = (i_use1 & w_m2e1) | (i_use2 & w_m2e2);
    end

endmodule

// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/kills, next-PC
// select, registered EXE bypass selects and the L1D wait watchdog.
module core_pipe_ctrl
    import core_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MEMWAIT_TO = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_val,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic              exe_we,
    input  logic              exe_is_load,
    input  logic              exe_brnch_tknn,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_l1d_val,
    input  logic              l1d_ack,
    input  logic              trap_in,
    output logic              fet_enb,
    output logic              dec_enb,
    output logic              exe_enb,
    output logic              mem_enb,
    output logic              fet_kill,
    output logic              dec_kill,
    output logic              exe_kill,
    output logic              pc_sel,
    output logic [3:0]        exe_bp,
    output logic              err_timeout
);

    localparam int unsigned     CNT_W   = $clog2(MEMWAIT_TO);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEMWAIT_TO - 1);

    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_err;
    logic [3:0]       r_bp;
    logic [3:0]       w_bp_nxt;
    logic             w_freeze;
    logic             w_flush;
    logic             w_exe_hit;
    logic             w_load_use;

    core_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .i_rs1     (dec_rs1),
        .i_rs2     (dec_rs2),
        .i_use1    (dec_use1),
        .i_use2    (dec_use2),
        .i_exe_rd  (exe_rd),
        .i_exe_we  (exe_we),
        .i_mem_rd  (mem_rd),
        .i_mem_we  (mem_we),
        .i_mask    (w_flush),
        .o_bp_nxt  (w_bp_nxt),
        .o_exe_hit (w_exe_hit)
    );

    // Event detection; an ack in the ack cycle lets pending branch/trap be re-evaluated
    always_comb begin
        w_flush    = (r_state == ST_FLUSH);
        w_freeze   = (r_state == ST_MEMWAIT) ? !l1d_ack : (mem_l1d_val && !l1d_ack);
        w_load_use = dec_val && exe_is_load && w_exe_hit && !w_flush;
        w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end

    // Next state and enable/kill decode, priority MEMWAIT > trap > branch > load-use
    always_comb begin
        fet_enb     = 1'b1;
        dec_enb     = 1'b1;
        exe_enb     = 1'b1;
        mem_enb     = 1'b1;
        fet_kill    = 1'b0;
        dec_kill    = 1'b0;
        exe_kill    = 1'b0;
        pc_sel      = 1'b0;
        w_state_nxt = ST_RUN;
        if (!rst_n) begin
            fet_enb  = 1'b0;
            dec_enb  = 1'b0;
            exe_enb  = 1'b0;
            mem_enb  = 1'b0;
            fet_kill = 1'b1;
            dec_kill = 1'b1;
            exe_kill = 1'b1;
        end else if (w_freeze) begin
            fet_enb     = 1'b0;
            dec_enb     = 1'b0;
            exe_enb     = 1'b0;
            mem_enb     = 1'b0;
            w_state_nxt = ST_MEMWAIT;
        end else if (trap_in) begin
            fet_kill = 1'b1;
            dec_kill = 1'b1;
            exe_kill = 1'b1;
        end else if (exe_brnch_tknn) begin
            pc_sel      = 1'b1;
            fet_kill    = 1'b1;
            dec_kill    = 1'b1;
            w_state_nxt = ST_FLUSH;
        end else if (w_load_use) begin
            fet_enb  = 1'b0;
            dec_enb  = 1'b0;
            dec_kill = 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_freeze && (r_state == ST_MEMWAIT)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // EXE bypass selects follow the D/E register: cleared on kill, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp <= BP_NONE;
        end else if (dec_kill) begin
            r_bp <= BP_NONE;
        end else if (exe_enb) begin
            r_bp <= w_bp_nxt;
        end
    end

    always_comb begin
        exe_bp      = r_bp;
        err_timeout = r_err;
    end

endmodule
